decode_pipe_stage: RTL

Registered, parametrised instruction-decode stage with valid/ready handshakes on both sides. It sits between fetch and execute and replaces the purely combinational decode path with a one-entry ID/EX output register. It adds register-file write-through bypass, load-use hazard bubbling, flush handling, RV32E register-count checking and saturating stall/flush performance counters for the benchmarking flow. Decode semantics (field extraction, immediate formats, `decode_controller` outputs) are unchanged.

---
 rtl/decode_pipe_stage_if.sv | 39 +++
 rtl/decode_pipe_stage.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/decode_pipe_stage_if.sv
// Fetch/writeback/execute-facing bus of the decode stage. CNT_W must match the
// stage's CNT_W. The stage itself takes the slave view.
interface decode_pipe_stage_if #(
  parameter int CNT_W = 32
);
  logic              id_flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instruction_in;
  logic              reg_file_wr_en;
  logic [4:0]        reg_file_wr_addr;
  logic [31:0]       reg_file_wr_data;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       op1, op2;
  logic [4:0]        rs1, rs2, rd;
  logic [31:0]       immediate;
  logic [6:0]        func7;
  logic [2:0]        func3;
  logic              alu_src, invalid_inst, m_type_inst, s_type_inst, wb_load, wb_reg_file;
  logic [8:0]        decoded_instruction;
  logic [CNT_W-1:0]  hazard_stall_cnt, flush_cnt;

  modport master (
    output id_flush, in_valid, instruction_in, reg_file_wr_en, reg_file_wr_addr,
           reg_file_wr_data, out_ready,
    input  in_ready, out_valid, op1, op2, rs1, rs2, rd, immediate, func7, func3,
           alu_src, invalid_inst, m_type_inst, s_type_inst, wb_load, wb_reg_file,
           decoded_instruction, hazard_stall_cnt, flush_cnt
  );

  modport slave (
    input  id_flush, in_valid, instruction_in, reg_file_wr_en, reg_file_wr_addr,
           reg_file_wr_data, out_ready,
    output in_ready, out_valid, op1, op2, rs1, rs2, rd, immediate, func7, func3,
           alu_src, invalid_inst, m_type_inst, s_type_inst, wb_load, wb_reg_file,
           decoded_instruction, hazard_stall_cnt, flush_cnt
  );
endinterface

// File: rtl/decode_pipe_stage.sv
// Registered RV32I/RV32E decode stage: regfile with write-through bypass, one-entry
// ID/EX register, load-use bubbling, flush, and saturating stall/flush counters.
module decode_pipe_stage #(
  parameter int NUM_REGS  = 32,
  parameter bit BYPASS_EN = 1'b1,
  parameter bit HAZARD_EN = 1'b1,
  parameter int CNT_W     = 32
) (
  input logic           clk,
  input logic           rst,
  decode_pipe_stage_if.slave bus
);
  localparam int RA = $clog2(NUM_REGS);

  typedef struct packed {
    logic [31:0] op1, op2;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [6:0]  func7;
    logic [2:0]  func3;
    logic        alu_src, invalid_inst, m_type, s_type, wb_load, wb_reg_file;
    logic [8:0]  dec;
  } bundle_t;

  logic [NUM_REGS-1:0][31:0] rf;
  bundle_t                   q, d;
  logic                      out_valid;
  logic [CNT_W-1:0]          hz_cnt, fl_cnt;

  logic [31:0] ins, imm_c, op1_c, op2_c;
  logic [6:0]  opc;
  logic [4:0]  rs1, rs2, rd;
  logic is_r, is_i, is_s, is_ld, is_u, is_b, is_j, is_auipc, is_jalr;
  logic rs1_used, rs2_used, rd_used, oob, known, hazard, advance;

  assign ins = bus.instruction_in;
  assign opc = ins[6:0];
  assign rs1 = ins[19:15];
  assign rs2 = ins[24:20];
  assign rd  = ins[11:7];

  assign is_r     = (opc == 7'b0110011);
  assign is_i     = (opc == 7'b0010011);
  assign is_s     = (opc == 7'b0100011);
  assign is_ld    = (opc == 7'b0000011);
  assign is_u     = (opc == 7'b0110111);
  assign is_b     = (opc == 7'b1100011);
  assign is_j     = (opc == 7'b1101111);
  assign is_auipc = (opc == 7'b0010111);
  assign is_jalr  = (opc == 7'b1100111);
  assign known    = is_r | is_i | is_s | is_ld | is_u | is_b | is_j | is_auipc | is_jalr;

  assign rs1_used = is_r | is_i | is_s | is_ld | is_b | is_jalr;
  assign rs2_used = is_r | is_s | is_b;
  assign rd_used  = is_r | is_i | is_ld | is_u | is_j | is_auipc | is_jalr;

  // RV32E: only register fields the instruction actually uses are range-checked
  assign oob = (NUM_REGS < 32) &&
               ((rs1_used && int'(rs1) >= NUM_REGS) ||
                (rs2_used && int'(rs2) >= NUM_REGS) ||
                (rd_used  && int'(rd)  >= NUM_REGS));

  always_comb begin
    imm_c = '0;
    if (is_i | is_ld | is_jalr) imm_c = {{20{ins[31]}}, ins[31:20]};
    else if (is_s)              imm_c = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    else if (is_b)              imm_c = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    else if (is_u | is_auipc)   imm_c = {ins[31:12], 12'b0};
    else if (is_j)              imm_c = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  end

  // Register read with x0 forced to zero and optional same-cycle write forwarding
  always_comb begin
    op1_c = '0;
    op2_c = '0;
    if (rs1 != 5'd0 && int'(rs1) < NUM_REGS) op1_c = rf[rs1[RA-1:0]];
    if (rs2 != 5'd0 && int'(rs2) < NUM_REGS) op2_c = rf[rs2[RA-1:0]];
    if (BYPASS_EN && bus.reg_file_wr_en && bus.reg_file_wr_addr != 5'd0) begin
      if (bus.reg_file_wr_addr == rs1) op1_c = bus.reg_file_wr_data;
      if (bus.reg_file_wr_addr == rs2) op2_c = bus.reg_file_wr_data;
    end
  end

  always_comb begin
    d              = '0;
    d.op1          = op1_c;
    d.op2          = op2_c;
    d.rs1          = rs1;
    d.rs2          = rs2;
    d.rd           = rd;
    d.imm          = imm_c;
    d.func7        = ins[31:25];
    d.func3        = ins[14:12];
    d.alu_src      = is_i | is_s | is_ld | is_u | is_auipc | is_jalr;
    d.invalid_inst = ~known | oob;
    d.m_type       = is_r & (ins[31:25] == 7'b0000001);
    d.s_type       = is_s;
    d.wb_load      = is_ld;
    d.wb_reg_file  = rd_used;
    d.dec          = {is_r, is_i, is_s, is_ld, is_u, is_b, is_j, is_auipc, is_jalr};
  end

  assign hazard  = HAZARD_EN && out_valid && q.wb_load && (q.rd != 5'd0) &&
                   ((rs1_used && rs1 == q.rd) || (rs2_used && rs2 == q.rd));
  assign advance = ~out_valid | bus.out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf <= '0;
    end else if (bus.reg_file_wr_en && bus.reg_file_wr_addr != 5'd0 &&
                 int'(bus.reg_file_wr_addr) < NUM_REGS) begin
      rf[bus.reg_file_wr_addr[RA-1:0]] <= bus.reg_file_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      q         <= '0;
      hz_cnt    <= '0;
      fl_cnt    <= '0;
    end else begin
      if (bus.id_flush)                    out_valid <= 1'b0;
      else if (advance && hazard)          out_valid <= 1'b0;
      else if (advance && bus.in_valid) begin
        out_valid <= 1'b1;
        q         <= d;
      end else if (advance)                out_valid <= 1'b0;
      if (bus.id_flush && !(&fl_cnt))                       fl_cnt <= fl_cnt + 1'b1;
      if (!bus.id_flush && advance && hazard && !(&hz_cnt)) hz_cnt <= hz_cnt + 1'b1;
    end
  end

  assign bus.in_ready            = bus.id_flush | (advance & ~hazard);
  assign bus.out_valid           = out_valid;
  assign bus.op1                 = q.op1;
  assign bus.op2                 = q.op2;
  assign bus.rs1                 = q.rs1;
  assign bus.rs2                 = q.rs2;
  assign bus.rd                  = q.rd;
  assign bus.immediate           = q.imm;
  assign bus.func7               = q.func7;
  assign bus.func3               = q.func3;
  assign bus.alu_src             = q.alu_src;
  assign bus.invalid_inst        = q.invalid_inst;
  assign bus.m_type_inst         = q.m_type;
  assign bus.s_type_inst         = q.s_type;
  assign bus.wb_load             = q.wb_load;
  assign bus.wb_reg_file         = q.wb_reg_file;
  assign bus.decoded_instruction = q.dec;
  assign bus.hazard_stall_cnt    = hz_cnt;
  assign bus.flush_cnt           = fl_cnt;
endmodule
